// File: rtl/dpram_be.sv
// Byte-lane dual-port RAM (one write, one read port) with a sequential clear engine.
// Read data after RD_LATENCY cycles at full rate, no backpressure; accesses are dropped while clearing.
module dpram_be #(
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 4,
  parameter int RD_LATENCY    = 1,
  parameter int BYPASS        = 1,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_req,
  output logic                  init_busy,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     data_out,
  output logic                  rd_valid,
  output logic                  rd_collision
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                idle;
  logic                wr_fire;
  logic                rd_fire;
  logic                hit;
  logic [DATA_W-1:0]   be_mask;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   merged;
  logic [DATA_W-1:0]   rd_result;

  logic                pre_vld;
  logic                pre_col;
  logic [DATA_W-1:0]   pre_dat;

  assign idle      = (state == IDLE);
  assign init_busy = (state == CLEAR);

  // Clear sweep: one word per cycle, cnt wraps back to 0 on the final word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= (INIT_ON_RESET != 0) ? CLEAR : IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          if (cnt == '1) begin
            state <= IDLE;
          end
          cnt <= cnt + 1'b1;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign wr_fire = !reset && idle && wr_en;
  assign rd_fire = !reset && idle && rd_en;

  always_comb begin
    be_mask = '0;
    for (int b = 0; b < NB; b++) begin
      be_mask[8*b +: 8] = {8{wr_be[b]}};
    end
  end

  // A write with no lanes enabled changes nothing, so it is not a collision.
  assign hit       = wr_fire && (wr_addr == rd_addr) && (|wr_be);
  assign rd_word   = mem[rd_addr];
  assign merged    = (rd_word & ~be_mask) | (data_in & be_mask);
  assign rd_result = ((BYPASS != 0) && hit) ? merged : rd_word;

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[cnt] <= '0;
      end else if (wr_en) begin
        for (int b = 0; b < NB; b++) begin
          if (wr_be[b]) begin
            mem[wr_addr][8*b +: 8] <= data_in[8*b +: 8];
          end
        end
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                s1_vld;
      logic                s1_col;
      logic [DATA_W-1:0]   s1_dat;

      always_ff @(posedge clk) begin
        if (reset) begin
          s1_vld <= 1'b0;
          s1_col <= 1'b0;
          s1_dat <= '0;
        end else begin
          s1_vld <= rd_fire;
          s1_col <= rd_fire && hit;
          if (rd_fire) begin
            s1_dat <= rd_result;
          end
        end
      end

      assign pre_vld = s1_vld;
      assign pre_col = s1_col;
      assign pre_dat = s1_dat;
    end else begin : g_lat1
      assign pre_vld = rd_fire;
      assign pre_col = rd_fire && hit;
      assign pre_dat = rd_result;
    end
  endgenerate

  // Output stage; data_out only moves on a valid result so it holds between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out     <= '0;
      rd_valid     <= 1'b0;
      rd_collision <= 1'b0;
    end else begin
      rd_valid     <= pre_vld;
      rd_collision <= pre_col;
      if (pre_vld) begin
        data_out <= pre_dat;
      end
    end
  end

endmodule

// File: doc/dpram_be.md
Name: dpram_be

Overview:
Parametrised successor to the team's 16x8 dual-port RAM, with one write port and one read port sharing clk.
- Adds byte-lane write enables, selectable read latency and optional same-address write-to-read forwarding.
- Replaces the single-cycle reset wipe with a sequential clear engine that sweeps one address per cycle, usable at reset or on request.
- Used as the generic scratch and buffer memory under FIFOs and packet buffers.

Parameters:
DATA_W, 16, data width in bits; must be a multiple of 8.
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
RD_LATENCY, 1, read latency in cycles; legal values 1 or 2.
BYPASS, 1, 1 = same-cycle same-address read returns merged new data; 0 = returns old data.
INIT_ON_RESET, 1, 1 = run the clear sweep after reset; 0 = memory content is undefined after reset.

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
clr_req  in  1  request a full memory clear; sampled in IDLE only
init_busy  out  1  high while the clear sweep runs
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write address
wr_be  in  DATA_W/8  byte-lane enables; bit b controls data_in[8b+7:8b]
data_in  in  DATA_W  write data
rd_en  in  1  read strobe
rd_addr  in  ADDR_W  read address
data_out  out  DATA_W  read data; holds its value between reads
rd_valid  out  1  one-cycle pulse marking new data_out
rd_collision  out  1  pulse aligned with rd_valid; the read hit a same-cycle write to the same address

Behaviour:
Reset:
- data_out=0, rd_valid=0, rd_collision=0, and the read pipeline is flushed.
- FSM goes to CLEAR if INIT_ON_RESET=1, else IDLE; clear counter=0.
- Reset asserted mid-sweep restarts the sweep at address 0.

FSM, states IDLE and CLEAR:
- IDLE -> CLEAR when clr_req=1. init_busy rises the next cycle.
- CLEAR writes all-zero to mem[cnt] every cycle, cnt = 0..DEPTH-1.
- After the cycle writing DEPTH-1: go to IDLE, init_busy=0, cnt=0. The sweep takes exactly DEPTH cycles.
- init_busy = (state==CLEAR).
- While CLEAR: wr_en, rd_en and clr_req are ignored and dropped, not queued. No rd_valid is generated. Reads already in the pipeline when CLEAR begins still complete.

Write, IDLE only, wr_en=1:
- Each lane with wr_be[b]=1 updates mem[wr_addr] lane b.
- Lanes with wr_be[b]=0 are unchanged. wr_be=0 is a no-op.

Read, IDLE only, rd_en=1:
- The word at rd_addr is sampled at edge T.
- RD_LATENCY=1: data_out and rd_valid update at edge T+1.
- RD_LATENCY=2: an extra register stage; they update at T+2.
- Back-to-back reads give one result per cycle at full throughput.
- With no read, data_out holds and rd_valid=0.

Collision (wr_en & rd_en, wr_addr==rd_addr, same cycle):
- BYPASS=1: result lane b = data_in lane b if wr_be[b], else the old mem lane.
- BYPASS=0: result is the old word.
- rd_collision=1 with that read's rd_valid, in either BYPASS mode. It is not set if wr_be=0.

Other rules:
- Write and read to different addresses in the same cycle are fully independent.
- Addresses always wrap within DEPTH; there is no out-of-range case.

Test Plan:
1. INIT_ON_RESET=1: reset 1 cycle, then release -> init_busy high for exactly 16 cycles. Then read every address -> each returns 0x0000 with rd_valid one cycle after rd_en.
2. Write addr 3 = 0xA5A5 with be=2'b11, then write addr 3 = 0x1234 with be=2'b01; read 3 -> 0xA534. Write with be=2'b00 then read -> still 0xA534.
3. BYPASS=1, mem[5]=0x00FF: same cycle wr addr 5, data 0xAB12, be=2'b10, plus rd addr 5 -> data_out=0xABFF and rd_collision=1. BYPASS=0, same stimulus -> 0x00FF with rd_collision=1.
4. RD_LATENCY=2: rd_en for addresses 1,2,3 on consecutive cycles (preloaded 0x0011, 0x0022, 0x0033) -> rd_valid high for 3 consecutive cycles, starting 2 cycles after the first rd_en, with data in order. data_out holds 0x0033 afterwards.
5. In IDLE, pulse clr_req, then issue wr_en to addr 7 during the sweep -> write dropped; after 16 busy cycles, read 7 -> 0x0000.
6. Reset asserted at sweep cycle 9 -> data_out=0, rd_valid=0, sweep restarts; init_busy stays high 16 more cycles after reset deasserts.
